// File: rtl/memarb_pkg.sv
`default_nettype none
// ============================================================================
// memarb_pkg : shared state encoding and default sizes for mem_arbiter
// Rev 1.0    : initial release
// ============================================================================
package memarb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      IBUSY = 2'b01,
      DBUSY = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam int c_DEF_WIDTH     = 32;
   localparam int c_DEF_MAXSTREAK = 4;

endpackage
`default_nettype wire

// File: rtl/memarb_streak.sv
`default_nettype none
// ============================================================================
// memarb_streak : counts data grants made while fetch waits; flags fetch priority
// Rev 1.0       : initial release
// ============================================================================
module memarb_streak #(
   parameter int MAXSTREAK = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_grant_d,
   input  logic i_grant_i,
   input  logic i_ireq,
   output logic o_fetch_prio
);

   localparam int c_CW = $clog2(MAXSTREAK + 1);

   logic [c_CW-1:0] r_streak;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_streak <= '0;
      end else if (i_grant_i) begin
         r_streak <= '0;
      end else if (i_grant_d) begin
         r_streak <= i_ireq ? r_streak + c_CW'(1) : '0;
      end
   end

   // Never exceeds MAXSTREAK: at the limit a waiting fetch always wins.
   assign o_fetch_prio = i_ireq && (r_streak == c_CW'(MAXSTREAK));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one memory port between fetch and load/store requesters
//               (define MEMARB_FAIR_EN to bound data-priority starvation)
// Rev 1.0     : initial release
// ============================================================================
module mem_arbiter
   import memarb_pkg::*;
#(
   parameter int WIDTH     = c_DEF_WIDTH,
   parameter int MAXSTREAK = c_DEF_MAXSTREAK
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ireq,
   input  logic [WIDTH-1:0] iadr,
   output logic [WIDTH-1:0] irdata,
   output logic             idone,
   input  logic             dreq,
   input  logic             dwrite,
   input  logic [WIDTH-1:0] dadr,
   input  logic [WIDTH-1:0] dwdata,
   output logic [WIDTH-1:0] drdata,
   output logic             ddone,
   output logic             memreq,
   output logic             memwrite,
   output logic [WIDTH-1:0] memadr,
   output logic [WIDTH-1:0] memwdata,
   input  logic [WIDTH-1:0] memrdata,
   input  logic             memack
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_grant_d;
   logic             w_grant_i;
   logic             w_ack;
   logic             w_fetch_prio;

   logic             r_memreq;
   logic             r_memwrite;
   logic [WIDTH-1:0] r_memadr;
   logic [WIDTH-1:0] r_memwdata;
   logic [WIDTH-1:0] r_irdata;
   logic [WIDTH-1:0] r_drdata;
   logic             r_idone;
   logic             r_ddone;

`ifdef MEMARB_FAIR_EN
   memarb_streak #(
      .MAXSTREAK    (MAXSTREAK)
   ) u_streak (
      .clk          (clk),
      .reset        (reset),
      .i_grant_d    (w_grant_d),
      .i_grant_i    (w_grant_i),
      .i_ireq       (ireq),
      .o_fetch_prio (w_fetch_prio)
   );
`else
   logic w_unused_maxstreak;
   assign w_unused_maxstreak = ^MAXSTREAK;
   assign w_fetch_prio       = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_grant_d   = 1'b0;
      w_grant_i   = 1'b0;
      w_ack       = 1'b0;
      case (r_state)
         IDLE: begin
            if (dreq && !w_fetch_prio) begin
               w_grant_d   = 1'b1;
               w_state_nxt = DBUSY;
            end else if (ireq) begin
               w_grant_i   = 1'b1;
               w_state_nxt = IBUSY;
            end
         end
         IBUSY, DBUSY: begin
            if (memack) begin
               w_ack       = 1'b1;
               w_state_nxt = DONE;
            end
         end
         // One idle edge lets the finished requester drop its req first.
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_memreq   <= 1'b0;
         r_memwrite <= 1'b0;
         r_memadr   <= '0;
         r_memwdata <= '0;
         r_irdata   <= '0;
         r_drdata   <= '0;
         r_idone    <= 1'b0;
         r_ddone    <= 1'b0;
      end else begin
         r_idone <= 1'b0;
         r_ddone <= 1'b0;
         if (w_grant_d) begin
            r_memreq   <= 1'b1;
            r_memwrite <= dwrite;
            r_memadr   <= dadr;
            r_memwdata <= dwdata;
         end else if (w_grant_i) begin
            r_memreq   <= 1'b1;
            r_memwrite <= 1'b0;
            r_memadr   <= iadr;
         end
         if (w_ack) begin
            r_memreq   <= 1'b0;
            r_memwrite <= 1'b0;
            if (r_state == IBUSY) begin
               r_irdata <= memrdata;
               r_idone  <= 1'b1;
            end else begin
               r_ddone <= 1'b1;
               if (!r_memwrite) begin
                  r_drdata <= memrdata;
               end
            end
         end
      end
   end

   assign memreq   = r_memreq;
   assign memwrite = r_memwrite;
   assign memadr   = r_memadr;
   assign memwdata = r_memwdata;
   assign irdata   = r_irdata;
   assign drdata   = r_drdata;
   assign idone    = r_idone;
   assign ddone    = r_ddone;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter with a delayed-ack memory
// Rev 1.0        : initial release
// ============================================================================
module tb_mem_arbiter;

   typedef struct {
      logic        is_d;
      logic        wr;
      logic [31:0] adr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          dly;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ireq = 1'b0;
   logic [31:0] iadr = '0;
   logic [31:0] irdata;
   logic        idone;
   logic        dreq = 1'b0;
   logic        dwrite = 1'b0;
   logic [31:0] dadr = '0;
   logic [31:0] dwdata = '0;
   logic [31:0] drdata;
   logic        ddone;
   logic        memreq;
   logic        memwrite;
   logic [31:0] memadr;
   logic [31:0] memwdata;
   logic [31:0] memrdata = '0;
   logic        memack;

   logic        resp_en = 1'b0;
   logic        man_ack = 1'b0;
   logic        rack = 1'b0;
   int          wcnt = 0;

   txn_t        q[$];
   int          nchk = 0;
   int          nerr = 0;

   assign memack = resp_en ? rack : man_ack;

   always #5 clk = ~clk;

   mem_arbiter #(.WIDTH(32), .MAXSTREAK(4)) dut (
      .clk(clk), .reset(reset),
      .ireq(ireq), .iadr(iadr), .irdata(irdata), .idone(idone),
      .dreq(dreq), .dwrite(dwrite), .dadr(dadr), .dwdata(dwdata),
      .drdata(drdata), .ddone(ddone),
      .memreq(memreq), .memwrite(memwrite), .memadr(memadr),
      .memwdata(memwdata), .memrdata(memrdata), .memack(memack)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: acks the head transaction after its programmed wait.
   always @(negedge clk) begin
      if (!resp_en) begin
         rack = 1'b0;
         wcnt = 0;
      end else if (rack) begin
         rack = 1'b0;
      end else if (memreq && q.size() > 0) begin
         if (wcnt >= q[0].dly) begin
            rack     = 1'b1;
            memrdata = q[0].rdata;
            wcnt     = 0;
         end else begin
            wcnt++;
         end
      end
   end

   // Monitor / scoreboard
   int          cyc = 0;
   logic        prev_done = 1'b0;
   logic [31:0] exp_drdata = '0;
   txn_t        t;

   always @(negedge clk) begin
      if (!reset) begin
         cyc        = 0;
         prev_done  = 1'b0;
         exp_drdata = '0;
      end else begin
         if (prev_done) chk("done_one_cycle", {31'd0, idone | ddone}, 32'd0);
         chk("memwrite_gated", {31'd0, memwrite & ~memreq}, 32'd0);
         if (memreq) begin
            cyc++;
            if (q.size() == 0) begin
               chk("memreq_unexpected", {31'd0, memreq}, 32'd0);
            end else begin
               chk("memadr", memadr, q[0].adr);
               chk("memwrite", {31'd0, memwrite}, {31'd0, q[0].wr});
               if (q[0].wr) chk("memwdata", memwdata, q[0].wdata);
            end
         end
         if (idone || ddone) begin
            if (q.size() == 0) begin
               chk("done_unexpected", {30'd0, idone, ddone}, 32'd0);
            end else begin
               t = q.pop_front();
               chk("done_kind", {30'd0, idone, ddone}, t.is_d ? 32'd1 : 32'd2);
               chk("memreq_cycles", cyc, t.dly + 1);
               if (!t.is_d) begin
                  chk("irdata", irdata, t.rdata);
               end else if (!t.wr) begin
                  chk("drdata_load", drdata, t.rdata);
                  exp_drdata = t.rdata;
               end else begin
                  chk("drdata_store_kept", drdata, exp_drdata);
               end
            end
            cyc = 0;
         end
         prev_done = idone | ddone;
      end
   end

   function automatic txn_t mk(input logic d, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input int dl);
      txn_t x;
      x.is_d = d; x.wr = w; x.adr = a; x.wdata = wd; x.rdata = rd; x.dly = dl;
      return x;
   endfunction

   // Single request; inputs are scrambled once memreq is up to prove latching.
   task automatic do_req(input txn_t x, output int lat);
      logic got;
      got = 1'b0;
      lat = 0;
      q.push_back(x);
      if (x.is_d) begin
         dreq = 1'b1; dwrite = x.wr; dadr = x.adr; dwdata = x.wdata;
      end else begin
         ireq = 1'b1; iadr = x.adr;
      end
      for (int k = 0; k < 50 && !got; k++) begin
         @(posedge clk); #1;
         lat++;
         if (memreq) begin
            dadr = 32'hFFFF_FFF0; dwdata = 32'h5A5A_5A5A; iadr = 32'hFFFF_FFF4;
         end
         if (x.is_d ? ddone : idone) got = 1'b1;
      end
      if (!got) chk("req_timeout", 32'd1, 32'd0);
      dreq = 1'b0; ireq = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int   lat;
      logic dn, in_done;
      int   dcnt;

      // 1: reset with memack high
      reset = 1'b0; man_ack = 1'b1; resp_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_memreq", {31'd0, memreq}, 32'd0);
      chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
      chk("rst_dones", {30'd0, idone, ddone}, 32'd0);
      chk("rst_irdata", irdata, 32'd0);
      chk("rst_drdata", drdata, 32'd0);
      chk("rst_memadr", memadr, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("idle_ack_ignored", {31'd0, memreq}, 32'd0);
      man_ack = 1'b0; resp_en = 1'b1;
      @(posedge clk); #1;

      // 2: fetch, ack one cycle after memreq
      do_req(mk(1'b0, 1'b0, 32'h4, 32'h0, 32'h2002_0005, 1), lat);
      chk("fetch_latency", lat, 32'd3);

      // 3: store, ack delayed three cycles
      do_req(mk(1'b1, 1'b1, 32'h54, 32'h7, 32'hDEAD_BEEF, 3), lat);
      chk("store_latency", lat, 32'd5);

      // a load then a store so the store must keep a nonzero drdata
      do_req(mk(1'b1, 1'b0, 32'h60, 32'h0, 32'h1234_5678, 0), lat);
      chk("load_latency", lat, 32'd2);
      do_req(mk(1'b1, 1'b1, 32'h64, 32'h99, 32'hCAFE_F00D, 2), lat);

      // 4: simultaneous requests, data first
      q.push_back(mk(1'b1, 1'b0, 32'h18, 32'h0, 32'h1111_2222, 0));
      q.push_back(mk(1'b0, 1'b0, 32'h8, 32'h0, 32'h3333_4444, 1));
      dreq = 1'b1; dwrite = 1'b0; dadr = 32'h18; ireq = 1'b1; iadr = 32'h8;
      dn = 1'b0; in_done = 1'b0;
      for (int k = 0; k < 60 && !(dn && in_done); k++) begin
         @(posedge clk); #1;
         if (ddone) begin dreq = 1'b0; dn = 1'b1; end
         if (idone) begin ireq = 1'b0; in_done = 1'b1; end
      end
      if (!(dn && in_done)) chk("both_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;

      // 5: reset during DBUSY aborts without a done pulse
      resp_en = 1'b0; man_ack = 1'b0;
      q.push_back(mk(1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 0));
      dreq = 1'b1; dwrite = 1'b0; dadr = 32'h30;
      for (int k = 0; k < 10 && !memreq; k++) begin
         @(posedge clk); #1;
      end
      chk("abort_memreq_up", {31'd0, memreq}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0; dreq = 1'b0;
      @(posedge clk); #1;
      chk("abort_memreq", {31'd0, memreq}, 32'd0);
      chk("abort_ddone", {31'd0, ddone}, 32'd0);
      q.delete();
      reset = 1'b1; man_ack = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk("late_ack_memreq", {31'd0, memreq}, 32'd0);
         chk("late_ack_dones", {30'd0, idone, ddone}, 32'd0);
      end
      man_ack = 1'b0; resp_en = 1'b1;
      @(posedge clk); #1;

      // 6: data re-requested back to back while fetch waits
      for (int k = 0; k < 6; k++) begin
`ifdef MEMARB_FAIR_EN
         if (k == 4) q.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0, 32'hBEEF_0001, 0));
`endif
         q.push_back(mk(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 32'hA000_0000 + 32'(k), 0));
      end
`ifndef MEMARB_FAIR_EN
      q.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0, 32'hBEEF_0001, 0));
`endif
      dreq = 1'b1; dwrite = 1'b0; dadr = 32'h100; ireq = 1'b1; iadr = 32'h40;
      dcnt = 0; in_done = 1'b0;
      for (int k = 0; k < 200 && !(dcnt == 6 && in_done); k++) begin
         @(posedge clk); #1;
         if (ddone) begin
            dcnt++;
            if (dcnt == 6) dreq = 1'b0;
            else dadr = 32'h100 + 32'(4 * dcnt);
         end
         if (idone) begin ireq = 1'b0; in_done = 1'b1; end
      end
      if (!(dcnt == 6 && in_done)) chk("streak_timeout", 32'd1, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
